// File: rtl/register_file_mp.sv
// Multi-read-port register file with r0 hard-wired to zero and a valid/ready debug dump engine.
// Optional REGFILE_BYPASS_EN: write-through of the in-flight write onto matching read ports.

module register_file_mp_rd_port #(
    parameter int NB_DATA     = 32,
    parameter int N_REGISTERS = 32,
    parameter int NB_REGISTER = 5
) (
    input  logic [N_REGISTERS-1:0][NB_DATA-1:0] registers,
    input  logic [NB_REGISTER-1:0]              sel,
    input  logic                                clear,
    input  logic                                bypass_hit,
    input  logic [NB_DATA-1:0]                  bypass_data,
    output logic [NB_DATA-1:0]                  data
);
    always_comb begin
        data = registers[sel];
        if (clear)
            data = '0;
        else if (bypass_hit)
            data = bypass_data;
    end
endmodule

module register_file_mp #(
    parameter int NB_DATA      = 32,
    parameter int N_REGISTERS  = 32,
    parameter int NB_REGISTER  = 5,
    parameter int N_READ_PORTS = 2
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset,
    input  logic                                 i_valid,
    input  logic [N_READ_PORTS*NB_REGISTER-1:0]  i_read_reg_sel,
    output logic [N_READ_PORTS*NB_DATA-1:0]      o_data_read_reg,
    input  logic [NB_REGISTER-1:0]               i_write_reg_sel,
    input  logic [NB_DATA-1:0]                   i_write_reg_data,
    input  logic                                 i_write_reg_enable,
    input  logic                                 i_dump_start,
    input  logic                                 i_dump_ready,
    output logic                                 o_dump_valid,
    output logic [NB_DATA-1:0]                   o_dump_data,
    output logic [NB_REGISTER-1:0]               o_dump_index,
    output logic                                 o_dump_busy,
    output logic                                 o_dump_done
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} dump_state_t;

    localparam logic [NB_REGISTER-1:0] LAST_INDEX = NB_REGISTER'(N_REGISTERS - 1);

    logic [N_REGISTERS-1:0][NB_DATA-1:0] registers;
    logic                                write_en;

    // r0 is never written, so it stays at its reset value of zero
    assign write_en = i_valid && i_write_reg_enable && (i_write_reg_sel != '0);

    always_ff @(posedge i_clock) begin
        if (i_reset)
            registers <= '0;
        else if (write_en)
            registers[i_write_reg_sel] <= i_write_reg_data;
    end

    for (genvar k = 0; k < N_READ_PORTS; k++) begin : g_rd
        logic hit;
`ifdef REGFILE_BYPASS_EN
        assign hit = write_en && (i_read_reg_sel[k*NB_REGISTER +: NB_REGISTER] == i_write_reg_sel);
`else
        assign hit = 1'b0;
`endif
        register_file_mp_rd_port #(
            .NB_DATA     (NB_DATA),
            .N_REGISTERS (N_REGISTERS),
            .NB_REGISTER (NB_REGISTER)
        ) u_rd (
            .registers   (registers),
            .sel         (i_read_reg_sel[k*NB_REGISTER +: NB_REGISTER]),
            .clear       (i_reset),
            .bypass_hit  (hit),
            .bypass_data (i_write_reg_data),
            .data        (o_data_read_reg[k*NB_DATA +: NB_DATA])
        );
    end

    dump_state_t             state, state_next;
    logic [NB_DATA-1:0]      dump_data, dump_data_next;
    logic [NB_REGISTER-1:0]  dump_index, dump_index_next, index_inc;

    assign index_inc = dump_index + 1'b1;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= IDLE;
            dump_data  <= '0;
            dump_index <= '0;
        end else begin
            state      <= state_next;
            dump_data  <= dump_data_next;
            dump_index <= dump_index_next;
        end
    end

    // Words are captured from the array at the load edge, so a same-edge write is not seen
    always_comb begin
        state_next      = state;
        dump_data_next  = dump_data;
        dump_index_next = dump_index;
        case (state)
            IDLE: begin
                if (i_dump_start) begin
                    dump_data_next  = registers[0];
                    dump_index_next = '0;
                    state_next      = SEND;
                end
            end
            SEND: begin
                if (i_dump_ready) begin
                    if (dump_index == LAST_INDEX) begin
                        state_next = DONE;
                    end else begin
                        dump_index_next = index_inc;
                        dump_data_next  = registers[index_inc];
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_dump_valid = (state == SEND);
    assign o_dump_busy  = (state != IDLE);
    assign o_dump_done  = (state == DONE);
    assign o_dump_data  = dump_data;
    assign o_dump_index = dump_index;
endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: stimulus pushes expectations, a negedge monitor checks.
module tb_register_file_mp;
    localparam int NBD  = 32;
    localparam int NREG = 32;
    localparam int NBR  = 5;
    localparam int NRP  = 3;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 i_reset, i_valid, i_write_reg_enable, i_dump_start, i_dump_ready;
    logic [NRP*NBR-1:0]   i_read_reg_sel;
    logic [NRP*NBD-1:0]   o_data_read_reg;
    logic [NBR-1:0]       i_write_reg_sel;
    logic [NBD-1:0]       i_write_reg_data;
    logic                 o_dump_valid, o_dump_busy, o_dump_done;
    logic [NBD-1:0]       o_dump_data;
    logic [NBR-1:0]       o_dump_index;

    always #5 clk = ~clk;

    register_file_mp #(
        .NB_DATA(NBD), .N_REGISTERS(NREG), .NB_REGISTER(NBR), .N_READ_PORTS(NRP)
    ) dut (
        .i_clock            (clk),
        .i_reset            (i_reset),
        .i_valid            (i_valid),
        .i_read_reg_sel     (i_read_reg_sel),
        .o_data_read_reg    (o_data_read_reg),
        .i_write_reg_sel    (i_write_reg_sel),
        .i_write_reg_data   (i_write_reg_data),
        .i_write_reg_enable (i_write_reg_enable),
        .i_dump_start       (i_dump_start),
        .i_dump_ready       (i_dump_ready),
        .o_dump_valid       (o_dump_valid),
        .o_dump_data        (o_dump_data),
        .o_dump_index       (o_dump_index),
        .o_dump_busy        (o_dump_busy),
        .o_dump_done        (o_dump_done)
    );

    typedef struct {
        int             idx;
        logic [NBD-1:0] data;
    } word_t;

    // Reference: architectural register contents plus dump progress (0 idle, 1 sending, 2 done)
    logic [NBD-1:0] model [NREG];
    word_t          dump_q [$];
    logic [NBD-1:0] rd_q [$];
    int             phase = 0;
    int             m_idx = 0;
    bit             rd_chk = 0, chk_rst = 0, final_chk = 0, to_err = 0;
    int             checks = 0, errors = 0;

    function automatic logic [NBD-1:0] exp_read(logic [NBR-1:0] s);
        if (i_reset) return '0;
        if (BYP && i_valid && i_write_reg_enable && i_write_reg_sel != 0 && s == i_write_reg_sel)
            return i_write_reg_data;
        return model[s];
    endfunction

    task automatic push_reads();
        for (int k = 0; k < NRP; k++)
            rd_q.push_back(exp_read(i_read_reg_sel[k*NBR +: NBR]));
        rd_chk = 1'b1;
    endtask

    task automatic rand_reads();
        for (int k = 0; k < NRP; k++)
            i_read_reg_sel[k*NBR +: NBR] = ($urandom_range(3) == 0) ? i_write_reg_sel : NBR'($urandom);
        push_reads();
    endtask

    task automatic set_all_sel(input int s);
        for (int k = 0; k < NRP; k++) i_read_reg_sel[k*NBR +: NBR] = NBR'(s);
    endtask

    // One clock edge: advance the reference with the inputs that the edge samples
    task automatic cyc();
        @(posedge clk);
        if (i_reset) begin
            for (int r = 0; r < NREG; r++) model[r] = '0;
            phase = 0;
            m_idx = 0;
            dump_q.delete();
        end else begin
            if (phase == 2) begin
                phase = 0;
            end else if (phase == 1) begin
                if (i_dump_ready) begin
                    if (m_idx == NREG - 1) phase = 2;
                    else begin
                        m_idx++;
                        dump_q.push_back('{m_idx, model[m_idx]});
                    end
                end
            end else if (i_dump_start) begin
                phase = 1;
                m_idx = 0;
                dump_q.push_back('{0, model[0]});
            end
            if (i_valid && i_write_reg_enable && i_write_reg_sel != 0)
                model[i_write_reg_sel] = i_write_reg_data;
        end
        #1;
        rd_chk  = 1'b0;
        chk_rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [NBD-1:0] act, input logic [NBD-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [NBD-1:0] e;
        word_t          w;
        if (rd_chk) begin
            for (int k = 0; k < NRP; k++) begin
                if (rd_q.size() == 0) chk("read_q_underflow", 32'd1, 32'd0);
                else begin
                    e = rd_q.pop_front();
                    chk($sformatf("read_port%0d", k), o_data_read_reg[k*NBD +: NBD], e);
                end
            end
        end
        chk("dump_valid", NBD'(o_dump_valid), NBD'(phase == 1));
        chk("dump_busy",  NBD'(o_dump_busy),  NBD'(phase != 0));
        chk("dump_done",  NBD'(o_dump_done),  NBD'(phase == 2));
        if (o_dump_valid) begin
            if (dump_q.size() == 0) chk("dump_unexpected_word", NBD'(o_dump_index), 32'hFFFF_FFFF);
            else begin
                w = dump_q[0];
                chk("dump_index", NBD'(o_dump_index), NBD'(w.idx));
                chk("dump_data", o_dump_data, w.data);
                if (i_dump_ready) void'(dump_q.pop_front());
            end
        end
        if (chk_rst) begin
            chk("reset_dump_data", o_dump_data, '0);
            chk("reset_dump_index", NBD'(o_dump_index), '0);
        end
        if (final_chk) begin
            chk("dump_q_drained", NBD'(dump_q.size()), '0);
            chk("read_q_drained", NBD'(rd_q.size()), '0);
            chk("wait_bound", NBD'(to_err), '0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        bit seen;
        for (int r = 0; r < NREG; r++) model[r] = '0;
        i_reset = 1; i_valid = 0; i_write_reg_enable = 0; i_dump_start = 0; i_dump_ready = 0;
        i_write_reg_sel = '0; i_write_reg_data = '0; i_read_reg_sel = '0;
        cyc();
        // reads held at zero while reset is high
        for (int k = 0; k < NRP; k++) i_read_reg_sel[k*NBR +: NBR] = NBR'(3 + k);
        push_reads(); cyc();
        i_reset = 0; chk_rst = 1;
        for (int i = 0; i < NREG; i++) begin
            for (int k = 0; k < NRP; k++) i_read_reg_sel[k*NBR +: NBR] = NBR'((i + k*11) % NREG);
            push_reads(); cyc();
        end
        // r0 discards writes
        i_valid = 1; i_write_reg_enable = 1; i_write_reg_sel = 0; i_write_reg_data = 32'hDEADBEEF;
        set_all_sel(0); push_reads(); cyc();
        i_write_reg_enable = 0; push_reads(); cyc();
        // write gated by i_valid
        i_write_reg_enable = 1; i_write_reg_sel = 5; i_write_reg_data = 32'h12345678; set_all_sel(5); cyc();
        i_valid = 0; i_write_reg_data = 32'hFFFFFFFF; push_reads(); cyc();
        i_valid = 1; i_write_reg_enable = 0; push_reads(); cyc();
        // same-cycle read of a register being written
        i_write_reg_enable = 1; i_write_reg_sel = 7; i_write_reg_data = 32'hA5A5A5A5; set_all_sel(7);
        push_reads(); cyc();
        i_write_reg_enable = 0; push_reads(); cyc();
        // random traffic
        for (int t = 0; t < 300; t++) begin
            i_valid = ($urandom_range(3) != 0); i_write_reg_enable = $urandom_range(1) != 0;
            i_write_reg_sel = NBR'($urandom); i_write_reg_data = $urandom;
            rand_reads(); cyc();
        end
        // preload rN = N*0x10
        i_valid = 1; i_write_reg_enable = 1;
        for (int n = 1; n < NREG; n++) begin
            i_write_reg_sel = NBR'(n); i_write_reg_data = NBD'(n * 32'h10); cyc();
        end
        i_write_reg_enable = 0;
        // dump with ready toggling, plus a start pulse while busy
        i_dump_start = 1; cyc(); i_dump_start = 0;
        seen = 0;
        for (int t = 0; t < 300; t++) begin
            i_dump_ready = (t % 2 == 0);
            i_dump_start = (t == 20);
            rand_reads(); cyc();
            if (phase == 2) seen = 1;
            if (seen && phase == 0) break;
        end
        if (!(seen && phase == 0)) to_err = 1;
        i_dump_start = 0;
        // dump with a same-edge write to r3, then reset at index 10
        i_dump_start = 1; i_dump_ready = 1; cyc(); i_dump_start = 0;
        seen = 0;
        for (int t = 0; t < 100; t++) begin
            i_valid = 1; i_write_reg_sel = 3; i_write_reg_data = 32'h77;
            i_write_reg_enable = (phase == 1 && m_idx == 2);
            i_reset = (phase == 1 && m_idx == 10);
            rand_reads(); cyc();
            if (i_reset) begin seen = 1; break; end
        end
        if (!seen) to_err = 1;
        i_reset = 0; i_write_reg_enable = 0;
        for (int t = 0; t < 3; t++) begin rand_reads(); cyc(); end
        // full dump under random ready and random writes
        i_dump_start = 1; cyc(); i_dump_start = 0;
        seen = 0;
        for (int t = 0; t < 400; t++) begin
            i_dump_ready = ($urandom_range(3) != 0);
            i_valid = $urandom_range(1) != 0; i_write_reg_enable = $urandom_range(1) != 0;
            i_write_reg_sel = NBR'($urandom); i_write_reg_data = $urandom;
            rand_reads(); cyc();
            if (phase == 2) seen = 1;
            if (seen && phase == 0) break;
        end
        if (!(seen && phase == 0)) to_err = 1;
        i_write_reg_enable = 0;
        final_chk = 1;
        cyc();
        #100;
        $display("FAIL monitor_finish: got no summary expected summary");
        $fatal(1);
    end
endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-read-port register file for the MIPS datapath decode stage, with a streaming debug dump engine. It replaces the fixed two-port bank: read-port count is configurable, writes are posedge-synchronous, and register 0 is hard-wired to zero. A valid/ready dump FSM lets the debug unit (UART path) read every register serially without stalling the pipeline.

## Interface
- NB_DATA, 32, data word width
- N_REGISTERS, 32, number of architectural registers (power of two, ≥2)
- NB_REGISTER, 5, index width, = log2(N_REGISTERS)
- N_READ_PORTS, 2, number of independent combinational read ports (1..4)

- i_clock  in  1  clock, all state updates on rising edge
- i_reset  in  1  reset i_reset, synchronous, active-high
- i_valid  in  1  pipeline advance; gates writes only
- i_read_reg_sel  in  N_READ_PORTS*NB_REGISTER  packed selects, port k at [k*NB_REGISTER +: NB_REGISTER]
- o_data_read_reg  out  N_READ_PORTS*NB_DATA  packed read data, port k at [k*NB_DATA +: NB_DATA]
- i_write_reg_sel  in  NB_REGISTER  write index
- i_write_reg_data  in  NB_DATA  write data
- i_write_reg_enable  in  1  write request
- i_dump_start  in  1  start-dump pulse, sampled in IDLE only
- i_dump_ready  in  1  consumer ready for dump word
- o_dump_valid  out  1  dump word valid
- o_dump_data  out  NB_DATA  dump word
- o_dump_index  out  NB_REGISTER  register index of o_dump_data
- o_dump_busy  out  1  FSM not in IDLE
- o_dump_done  out  1  one-cycle pulse after last word accepted

## Operation
- Write: at rising edge, if i_valid && i_write_reg_enable && i_write_reg_sel != 0 -> registers[sel] <= data. Writes to index 0 are discarded.
- Read: each port combinational, o_data_read_reg[k] = registers[sel_k]; sel 0 always returns 0. Not gated by i_valid. While i_reset high all ports return 0.
- Reset: on edge with i_reset high, all registers cleared, FSM -> IDLE; reset wins over a same-edge write.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: o_dump_busy=0. If i_dump_start -> load o_dump_data=registers[0], o_dump_index=0, o_dump_valid=1, go SEND.
  - SEND: transfer when o_dump_valid && i_dump_ready. On transfer with index < N_REGISTERS-1: index+1, o_dump_data loaded from array at new index. On transfer with index == N_REGISTERS-1: o_dump_valid=0, go DONE. Without ready, data/index held stable.
  - DONE: o_dump_done=1 for exactly one cycle, then IDLE.
- Dump words are snapshots from the array at load edge, pre-write: a same-edge write to the loaded index is not seen in that word. Later writes never alter a presented word.
- i_dump_start ignored while busy. Dump never blocks reads/writes.

## Timing
- Read latency 0 (combinational); write visible on reads the cycle after its edge (see Configuration).
- Dump: start sampled edge N -> o_dump_valid=1 after edge N; with ready held high, one word per cycle, N_REGISTERS words, o_dump_done high the cycle after the last transfer; start-to-done = N_REGISTERS+1 cycles.
- Reset values: o_dump_valid=0, o_dump_data=0, o_dump_index=0, o_dump_busy=0, o_dump_done=0; read outputs 0.
- Reset mid-dump: next cycle IDLE, all dump outputs 0, no done pulse.
- Index counter has no wrap: terminates at N_REGISTERS-1.

## Configuration
- REGFILE_BYPASS_EN defined: a read port whose sel equals i_write_reg_sel (≠0) while i_valid && i_write_reg_enable returns i_write_reg_data combinationally (write-through, same cycle). Dump path is never bypassed.
- Undefined: reads return stored contents only; new value visible the cycle after the write edge.

## Test plan
- Reset, then read all indices on every port -> all 0; write 0xDEADBEEF to r0 -> r0 still reads 0.
- Write 0x12345678 to r5 with i_valid=1, then same write of 0xFFFFFFFF with i_valid=0 -> r5 reads 0x12345678 on all ports.
- Write r7=0xA5A5A5A5 and read r7 same cycle -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, old value 0 without; next cycle 0xA5A5A5A5 both.
- Preload rN=N*0x10, pulse dump_start, ready toggling 1/0 -> 32 words in order, index 0..31, values N*0x10, held while ready low; done pulses once after index 31.
- Dump with ready=1, write r3=0x77 on the edge r3 is loaded -> dump shows old r3; assert i_reset at index 10 -> valid=0, busy=0 next cycle, no done pulse.
